// File: rtl/icache_assoc_fetch_pkg.sv
// Shared defaults and FSM encoding for the set-associative IF cache.
package icache_assoc_fetch_pkg;

  localparam int ICACHE_INDEX_W = 7;
  localparam int ICACHE_WAYS    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MISS   = 2'd1,
    ST_CANCEL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/icache_assoc_fetch_way.sv
// One storage way: valid/tag/data per set, synchronous write, asynchronous read.
module icache_way
  import icache_assoc_fetch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 23,
  parameter int INDEX_W = ICACHE_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_idx,
  input  logic [TAG_W-1:0]   i_wtag,
  input  logic [DATA_W-1:0]  i_wdata,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [DATA_W-1:0]  o_data
);

  localparam int SETS = 1 << INDEX_W;

  logic              r_valid [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS];
  logic [DATA_W-1:0] r_data  [SETS];

  // Reset and flush both win over a fill landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= 1'b0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_idx]  <= i_wtag;
      r_data[i_idx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

endmodule

// File: rtl/icache_assoc_fetch.sv
// Set-associative (1 or 2 way) instruction cache with same-cycle hits, a
// req/ack fill FSM, per-set LRU, fence.i flush and jmp-safe fill cancellation.
module icache_assoc_fetch
  import icache_assoc_fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int WAYS    = ICACHE_WAYS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              jmp,
  input  logic              flush,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              if_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int SETS  = 1 << INDEX_W;

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_lru [SETS];

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [WAYS-1:0]    w_vld, w_hit;
  logic [TAG_W-1:0]   w_rtag  [WAYS];
  logic [DATA_W-1:0]  w_rdata [WAYS];
  logic               w_any_hit, w_hit_way, w_victim, w_pc_match;
  logic [DATA_W-1:0]  w_hit_data;

  logic               w_inst_valid, w_fill_we, w_lru_upd, w_latch;
  logic [DATA_W-1:0]  w_inst;
  logic [ADDR_W-1:0]  w_pc_out;

  assign w_idx      = fetch_pc[INDEX_W+1:2];
  assign w_tag      = fetch_pc[ADDR_W-1:INDEX_W+2];
  assign w_any_hit  = |w_hit;
  assign w_pc_match = fetch_req && (fetch_pc[ADDR_W-1:2] == r_pc[ADDR_W-1:2]);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic w_we;
    assign w_we = w_fill_we && (int'(w_victim) == g);
    icache_way #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .INDEX_W(INDEX_W)
    ) u_way (
      .clk    (clk),
      .rst    (rst),
      .i_flush(flush),
      .i_we   (w_we),
      .i_idx  (w_idx),
      .i_wtag (w_tag),
      .i_wdata(mem_data),
      .o_valid(w_vld[g]),
      .o_tag  (w_rtag[g]),
      .o_data (w_rdata[g])
    );
    assign w_hit[g] = w_vld[g] && (w_rtag[g] == w_tag);
  end

  // A fill only writes when fetch_pc matches the latched pc, so the lookup
  // index doubles as the fill index and victim selection reads the right set.
  if (WAYS == 2) begin : g_two
    assign w_hit_way  = w_hit[1];
    assign w_hit_data = w_hit[1] ? w_rdata[1] : w_rdata[0];
    assign w_victim   = !w_vld[0] ? 1'b0 : (!w_vld[1] ? 1'b1 : r_lru[w_idx]);
  end else if (WAYS == 1) begin : g_one
    assign w_hit_way  = 1'b0;
    assign w_hit_data = w_rdata[0];
    assign w_victim   = 1'b0;
  end else begin : g_bad
    $error("icache_assoc_fetch: WAYS must be 1 or 2");
    assign w_hit_way  = 1'b0;
    assign w_hit_data = '0;
    assign w_victim   = 1'b0;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_inst_valid = 1'b0;
    w_inst       = '0;
    w_pc_out     = '0;
    w_fill_we    = 1'b0;
    w_lru_upd    = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fetch_req && !jmp) begin
          if (w_any_hit) begin
            w_inst_valid = 1'b1;
            w_inst       = w_hit_data;
            w_pc_out     = fetch_pc;
            w_lru_upd    = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        if (mem_ack) begin
          w_state_nxt = ST_IDLE;
          if (!jmp && w_pc_match) begin
            w_inst_valid = 1'b1;
            w_inst       = mem_data;
            w_pc_out     = r_pc;
            w_fill_we    = !flush && !rst;
          end
        end else if (jmp) begin
          w_state_nxt = ST_CANCEL;
        end
      end
      ST_CANCEL: begin
        if (mem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_latch) r_pc <= {fetch_pc[ADDR_W-1:2], 2'b00};
  end

  // lru names the way to evict next; a fill and a hit never share a cycle,
  // but the fill is listed first so it wins if that ever changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) r_lru[s] <= 1'b0;
    end else if (WAYS == 2) begin
      if (w_fill_we)      r_lru[w_idx] <= ~w_victim;
      else if (w_lru_upd) r_lru[w_idx] <= ~w_hit_way;
    end
  end

  assign inst_valid = !rst && w_inst_valid;
  assign inst_o     = rst ? '0 : w_inst;
  assign pc_o       = rst ? '0 : w_pc_out;
  assign if_stall   = !rst && fetch_req && !w_inst_valid;
  assign mem_req    = !rst && (r_state != ST_IDLE);
  assign mem_addr   = r_pc;

endmodule
